// File: rtl/mbgd_dot_gen_pkg.sv
// Shared MBGD definitions used by the dot-product producer and the adder stage.
// Latency: none (types, constants and a pure helper function only).
// Backpressure: not applicable.
package mbgd_pkg;

    // Default geometry of one MBGD row.
    localparam int DEF_N     = 8;
    localparam int DEF_N_BIT = 3;
    localparam int DEF_DW    = 8;

    // Width of one product slice on the dot_products bus.
    localparam int PW = 2 * DEF_DW;

    // Producer FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit offset of slice i on a bus built from pw-bit slices.
    function automatic int slice_off(input int pw, input int i);
        return pw * i;
    endfunction

endpackage

// File: rtl/mbgd_dot_gen_if.sv
// Row-in / products-out bus between the row source, the dot generator and the adder.
// Latency: none (wires only).
// Backpressure: in_valid/in_ready on the row side, out_valid/out_ready on the product side.
interface mbgd_dot_gen_if
    import mbgd_pkg::*;
#(
    parameter int N  = DEF_N,
    parameter int DW = DEF_DW
);

    logic                  in_valid;
    logic                  in_ready;
    logic [DW*N-1:0]       x_row;
    logic [DW*N-1:0]       w_row;
    logic                  abort;
    logic                  out_valid;
    logic                  out_ready;
    logic [2*DW*N-1:0]     dot_products;
    logic                  busy;

    // Environment side: supplies rows and consumes products.
    modport master (
        output in_valid, x_row, w_row, abort, out_ready,
        input  in_ready, out_valid, dot_products, busy
    );

    // Dot generator side.
    modport slave (
        input  in_valid, x_row, w_row, abort, out_ready,
        output in_ready, out_valid, dot_products, busy
    );

endinterface

// File: rtl/mbgd_dot_gen_mult.sv
// Unsigned DW x DW -> 2*DW multiplier, exact product.
// Latency: combinational.
// Backpressure: none.
module mbgd_mult #(
    parameter int DW = 8
) (
    input  logic [DW-1:0]   a,
    input  logic [DW-1:0]   b,
    output logic [2*DW-1:0] p
);

    localparam int PWL = 2 * DW;

    // Operands are widened first so the full product is kept.
    assign p = PWL'(a) * PWL'(b);

endmodule

// File: rtl/mbgd_dot_gen.sv
// Serial elementwise x*w for one row, packed onto the dot_products bus for the adder.
// Latency: accept at edge T0, slice i written at T0+1+i, out_valid high after T0+N.
// Backpressure: one row at a time; products held stable with out_valid until out_ready.
module mbgd_dot_gen
    import mbgd_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int N_bit = DEF_N_BIT,
    parameter int DW    = DEF_DW
) (
    input  logic          clk,
    input  logic          resetn,
    mbgd_dot_gen_if.slave bus
);

    localparam int               PWL  = 2 * DW;
    localparam logic [N_bit-1:0] LAST = N_bit'(N - 1);

    state_t                  state_q;
    state_t                  state_d;
    logic [N_bit-1:0]        idx;
    logic [N-1:0][DW-1:0]    x_hold;
    logic [N-1:0][DW-1:0]    w_hold;
    logic [N-1:0][PWL-1:0]   dot_q;
    logic [DW-1:0]           x_sel;
    logic [DW-1:0]           w_sel;
    logic [PWL-1:0]          prod;
    logic                    accept;
    logic                    step;
    logic                    last;

    // abort overrides both a new-row accept and a CALC step on the same edge.
    assign accept = (state_q == IDLE) && bus.in_valid && !bus.abort;
    assign step   = (state_q == CALC) && !bus.abort;
    assign last   = (idx == LAST);

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: abort returns to IDLE from anywhere; CALC exits on the last index.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept)                state_d = CALC;
            CALC: if (bus.abort)             state_d = IDLE;
                  else if (last)             state_d = DONE;
            DONE: if (bus.abort || bus.out_ready) state_d = IDLE;
            default:                         state_d = IDLE;
        endcase
    end

    // State-decoded handshake and status outputs.
    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b0;
        case (state_q)
            IDLE: bus.in_ready = 1'b1;
            CALC: bus.busy     = 1'b1;
            DONE: begin
                bus.busy      = 1'b1;
                bus.out_valid = 1'b1;
            end
            default: bus.in_ready = 1'b0;
        endcase
    end

    // Row capture, index walk and slice write; slices are left untouched outside CALC.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            x_hold <= '0;
            w_hold <= '0;
            dot_q  <= '0;
            idx    <= '0;
        end else begin
            if (accept) begin
                x_hold <= bus.x_row;
                w_hold <= bus.w_row;
            end
            if (step) begin
                dot_q[idx] <= prod;
            end
            // Index is cleared on accept, abort and CALC exit, so it never wraps.
            if (accept || bus.abort || (step && last)) begin
                idx <= '0;
            end else if (step) begin
                idx <= idx + 1'b1;
            end
        end
    end

    assign x_sel = x_hold[idx];
    assign w_sel = w_hold[idx];

    mbgd_mult #(
        .DW (DW)
    ) u_mult (
        .a (x_sel),
        .b (w_sel),
        .p (prod)
    );

    assign bus.dot_products = dot_q;

endmodule

// File: tb/tb_mbgd_dot_gen.sv
// Self-checking bench for mbgd_dot_gen: table vectors, random rows and handshake corner cases.
// Latency: expects out_valid exactly N edges after the accept edge.
// Backpressure: stalls out_ready to check the bus holds, and checks ignored rows.
module tb_mbgd_dot_gen;
    import mbgd_pkg::*;

    localparam int N  = 8;
    localparam int DW = 8;
    localparam int PB = 2 * DW;
    localparam int BW = PB * N;

    typedef struct {
        logic [DW*N-1:0] x;
        logic [DW*N-1:0] w;
        logic [BW-1:0]   exp;
        int              dly;
    } vec_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   tests = 0;
    int   fails = 0;
    vec_t tbl [6];

    always #5 clk = ~clk;

    mbgd_dot_gen_if #(.N(N), .DW(DW)) bus ();

    mbgd_dot_gen #(
        .N     (N),
        .N_bit (3),
        .DW    (DW)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    task automatic check(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: product i = x[i]*w[i] placed at slice i.
    function automatic logic [BW-1:0] model(input logic [DW*N-1:0] x, input logic [DW*N-1:0] w);
        logic [BW-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) begin
            r[slice_off(PB, i) +: PB] = PB'(x[i*DW +: DW]) * PB'(w[i*DW +: DW]);
        end
        return r;
    endfunction

    // What the downstream adder would produce from the bus.
    function automatic int adder_sum(input logic [BW-1:0] d);
        int s;
        s = 0;
        for (int i = 0; i < N; i++) s += int'(d[slice_off(PB, i) +: PB]);
        return s;
    endfunction

    // Presents a row and returns at the negedge just after the accept edge.
    task automatic start_row(input string nm, input logic [DW*N-1:0] x, input logic [DW*N-1:0] w);
        @(negedge clk);
        check({nm, "_in_ready"}, BW'(bus.in_ready), BW'(1));
        bus.x_row    = x;
        bus.w_row    = w;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.x_row    = ~x;
        bus.w_row    = ~w;
    endtask

    // Counts edges from the accept edge to out_valid, bounded, then checks the bus.
    task automatic wait_done(input string nm, input logic [BW-1:0] exp);
        int cyc;
        cyc = 0;
        while (!bus.out_valid && cyc < 4 * N) begin
            @(negedge clk);
            cyc++;
        end
        check({nm, "_latency"}, BW'(cyc), BW'(N));
        check({nm, "_dot"}, bus.dot_products, exp);
    endtask

    task automatic consume(input string nm);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({nm, "_idle"}, BW'({bus.out_valid, bus.in_ready, bus.busy}), BW'(3'b010));
    endtask

    task automatic run_row(input string nm, input logic [DW*N-1:0] x, input logic [DW*N-1:0] w,
                           input int dly, input logic [BW-1:0] exp);
        start_row(nm, x, w);
        wait_done(nm, exp);
        for (int d = 0; d < dly; d++) begin
            @(negedge clk);
            check({nm, "_hold"}, BW'({bus.out_valid, bus.in_ready}), BW'(2'b10));
            check({nm, "_stable"}, bus.dot_products, exp);
        end
        consume(nm);
    endtask

    initial begin
        logic [DW*N-1:0] xa, wa, xb, wb;
        logic [BW-1:0]   prev, part, ea;
        int              seen;

        tbl[0] = '{64'h0807060504030201, 64'h0202020202020202,
                   128'h0010_000E_000C_000A_0008_0006_0004_0002, 0};
        tbl[1] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF,
                   128'hFE01_FE01_FE01_FE01_FE01_FE01_FE01_FE01, 1};
        tbl[2] = '{64'h0807060504030201, 64'h0807060504030201,
                   128'h0040_0031_0024_0019_0010_0009_0004_0001, 0};
        tbl[3] = '{64'h8080808080808080, 64'h0202020202020202,
                   128'h0100_0100_0100_0100_0100_0100_0100_0100, 2};
        tbl[4] = '{64'hFF00FF00FF00FF00, 64'h01FF01FF01FF01FF,
                   128'h00FF_0000_00FF_0000_00FF_0000_00FF_0000, 0};
        tbl[5] = '{64'h0000000000000000, 64'hFFFFFFFFFFFFFFFF, 128'h0, 1};

        bus.in_valid  = 1'b0;
        bus.x_row     = '0;
        bus.w_row     = '0;
        bus.abort     = 1'b0;
        bus.out_ready = 1'b0;

        // Reset state.
        repeat (2) @(negedge clk);
        check("reset_flags", BW'({bus.in_ready, bus.out_valid, bus.busy}), BW'(3'b100));
        check("reset_dot", bus.dot_products, '0);
        resetn = 1'b1;

        // Table vectors.
        for (int k = 0; k < 6; k++) begin
            run_row($sformatf("tbl%0d", k), tbl[k].x, tbl[k].w, tbl[k].dly, tbl[k].exp);
            if (k == 0) check("basic_adder_sum", BW'(adder_sum(bus.dot_products)), BW'(72));
        end

        // Backpressure: 5 stall cycles, a new row offered meanwhile must wait.
        xa = {$urandom, $urandom}; wa = {$urandom, $urandom};
        xb = {$urandom, $urandom}; wb = {$urandom, $urandom};
        ea = model(xa, wa);
        start_row("bp_a", xa, wa);
        wait_done("bp_a", ea);
        bus.x_row = xb; bus.w_row = wb; bus.in_valid = 1'b1;
        for (int d = 0; d < 5; d++) begin
            @(negedge clk);
            check("bp_hold", BW'({bus.out_valid, bus.in_ready}), BW'(2'b10));
            check("bp_stable", bus.dot_products, ea);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("bp_release", BW'({bus.out_valid, bus.in_ready, bus.busy}), BW'(3'b010));
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("bp_b_accepted", BW'({bus.in_ready, bus.busy}), BW'(2'b01));
        wait_done("bp_b", model(xb, wb));
        consume("bp_b");

        // Abort with idx=3: slices 0..2 rewritten, rest keep the previous row.
        prev = bus.dot_products;
        xa = {$urandom, $urandom}; wa = {$urandom, $urandom};
        ea = model(xa, wa);
        start_row("abort", xa, wa);
        repeat (3) @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check("abort_flags", BW'({bus.in_ready, bus.out_valid, bus.busy}), BW'(3'b100));
        part = prev;
        part[3*PB-1:0] = ea[3*PB-1:0];
        check("abort_partial", bus.dot_products, part);
        seen = 0;
        for (int c = 0; c < 2 * N; c++) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        check("abort_no_valid", BW'(seen), BW'(0));
        xb = {$urandom, $urandom}; wb = {$urandom, $urandom};
        run_row("after_abort", xb, wb, 0, model(xb, wb));

        // abort together with out_ready in DONE, then abort together with in_valid in IDLE.
        xa = {$urandom, $urandom}; wa = {$urandom, $urandom};
        ea = model(xa, wa);
        start_row("sim", xa, wa);
        wait_done("sim", ea);
        bus.abort = 1'b1; bus.out_ready = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0; bus.out_ready = 1'b0;
        check("sim_done_abort", BW'({bus.in_ready, bus.out_valid, bus.busy}), BW'(3'b100));
        check("sim_dot_kept", bus.dot_products, ea);
        bus.abort = 1'b1; bus.in_valid = 1'b1; bus.x_row = xb; bus.w_row = wb;
        @(negedge clk);
        bus.abort = 1'b0; bus.in_valid = 1'b0;
        check("sim_idle_no_accept", BW'({bus.in_ready, bus.busy}), BW'(2'b10));

        // Asynchronous reset in the middle of CALC.
        start_row("rst", xa, wb);
        repeat (2) @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        check("rst_flags", BW'({bus.in_ready, bus.out_valid, bus.busy}), BW'(3'b100));
        check("rst_dot", bus.dot_products, '0);
        @(negedge clk);
        resetn = 1'b1;
        run_row("after_rst", xb, wa, 1, model(xb, wa));

        // Random rows against the reference model.
        for (int r = 0; r < 24; r++) begin
            xa = {$urandom, $urandom};
            wa = {$urandom, $urandom};
            run_row($sformatf("rnd%0d", r), xa, wa, int'($urandom_range(0, 3)), model(xa, wa));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
